pattern_engine: RTL and testbench

Parametrised background/pattern generator for the VGA demoscene pipeline. It sits between the sync generator and the pad outputs. It keeps a frame-synchronous scroll counter and a mode sequencer, with modes either auto-cycled or host-selected. Each pixel it outputs a registered RGB value: background pattern, or sprite colour inside a horizontal window.

---
 rtl/pattern_pkg.sv | 21 ++
 rtl/frame_sequencer.sv | 77 +++++++
 rtl/pattern_engine.sv | 132 +++++++++++++
 tb/tb_pattern_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared mode encoding for the VGA background/pattern generator.
package pattern_pkg;

    localparam int MODE_W     = 4;
    localparam int MODE_COUNT = 11;

    typedef enum logic [MODE_W-1:0] {
        MODE_SOLID     = 4'd0,
        MODE_VSTRIPE   = 4'd1,
        MODE_HSTRIPE   = 4'd2,
        MODE_SCROLL_XP = 4'd3,
        MODE_SCROLL_XN = 4'd4,
        MODE_SCROLL_YP = 4'd5,
        MODE_SCROLL_YN = 4'd6,
        MODE_SCROLL_PP = 4'd7,
        MODE_SCROLL_NP = 4'd8,
        MODE_SCROLL_PN = 4'd9,
        MODE_SCROLL_NN = 4'd10
    } mode_e;

endpackage

// File: rtl/frame_sequencer.sv
// Frame-synchronous state: vsync edge detect, scroll counter, mode FSM.
module frame_sequencer
    import pattern_pkg::*;
#(
    parameter int POS_BITS        = 10,
    parameter int FRAMES_PER_MODE = 128,
    parameter int SCROLL_STEP     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vsync,
    input  logic                auto_en,
    input  logic [MODE_W-1:0]   mode_sel,
    output logic                frame_tick,
    output logic [POS_BITS-1:0] scroll,
    output mode_e               mode
);

    localparam int CNT_W =
        (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(FRAMES_PER_MODE - 1);

    logic                vsync_q;
    logic                tick_q;
    logic [POS_BITS-1:0] scroll_q, scroll_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    mode_e               mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            tick_q   <= 1'b0;
            scroll_q <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_SOLID;
        end else begin
            vsync_q  <= vsync;
            tick_q   <= vsync & ~vsync_q;
            scroll_q <= scroll_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
        end
    end

    // All frame state moves on the registered tick, never mid-frame.
    always_comb begin
        scroll_d = scroll_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        if (tick_q) begin
            scroll_d = scroll_q + POS_BITS'(SCROLL_STEP);
            if (auto_en) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (mode_q == MODE_SCROLL_NN)
                        mode_d = MODE_SOLID;
                    else
                        mode_d = mode_e'(mode_q + 4'd1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
                if (mode_sel >= MODE_W'(MODE_COUNT))
                    mode_d = MODE_SOLID;
                else
                    mode_d = mode_e'(mode_sel);
            end
        end
    end

    assign frame_tick = tick_q;
    assign scroll     = scroll_q;
    assign mode       = mode_q;

endmodule

// File: rtl/pattern_engine.sv
// Background pattern + sprite window pixel generator, registered output.
// Build option: PATTERN_ENGINE_SPRITE_KEY_EN makes all-zero sprite pixels transparent.
module pattern_engine
    import pattern_pkg::*;
#(
    parameter int COLOR_BITS      = 2,
    parameter int POS_BITS        = 10,
    parameter int FRAMES_PER_MODE = 128,
    parameter int SCROLL_STEP     = 1,
    parameter int WIN_X0          = 100,
    parameter int WIN_X1          = 500,
    parameter logic [3*COLOR_BITS-1:0] SOLID_RGB = 6'b110000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [POS_BITS-1:0]     hpos,
    input  logic [POS_BITS-1:0]     vpos,
    input  logic                    visible,
    input  logic                    vsync,
    input  logic                    auto_en,
    input  logic [3:0]              mode_sel,
    input  logic                    win_en,
    input  logic [3*COLOR_BITS-1:0] sprite_rgb,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic [3:0]              mode,
    output logic                    frame_tick
);

    localparam int PIX_W = 3 * COLOR_BITS;
    localparam logic [POS_BITS-1:0] X0 = POS_BITS'(WIN_X0);
    localparam logic [POS_BITS-1:0] X1 = POS_BITS'(WIN_X1);

    mode_e               mode_w;
    logic [POS_BITS-1:0] scroll;
    logic [POS_BITS-1:0] mx, my;
    logic [PIX_W-1:0]    bg, pix_d, rgb_q;
    logic                in_win, opaque, msb, lsb;

    frame_sequencer #(
        .POS_BITS       (POS_BITS),
        .FRAMES_PER_MODE(FRAMES_PER_MODE),
        .SCROLL_STEP    (SCROLL_STEP)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync     (vsync),
        .auto_en   (auto_en),
        .mode_sel  (mode_sel),
        .frame_tick(frame_tick),
        .scroll    (scroll),
        .mode      (mode_w)
    );

    always_comb begin
        mx = hpos;
        my = vpos;
        case (mode_w)
            MODE_SCROLL_XP: mx = hpos + scroll;
            MODE_SCROLL_XN: mx = hpos - scroll;
            MODE_SCROLL_YP: my = vpos + scroll;
            MODE_SCROLL_YN: my = vpos - scroll;
            MODE_SCROLL_PP: begin
                mx = hpos + scroll;
                my = vpos + scroll;
            end
            MODE_SCROLL_NP: begin
                mx = hpos - scroll;
                my = vpos + scroll;
            end
            MODE_SCROLL_PN: begin
                mx = hpos + scroll;
                my = vpos - scroll;
            end
            MODE_SCROLL_NN: begin
                mx = hpos - scroll;
                my = vpos - scroll;
            end
            default: ;
        endcase
    end

    // Scroll modes: channel MSB from a coarse coordinate bit, the rest dither.
    always_comb begin
        bg  = '0;
        msb = 1'b0;
        lsb = 1'b0;
        case (mode_w)
            MODE_SOLID:   bg = SOLID_RGB;
            MODE_VSTRIPE: bg = hpos[PIX_W-1:0];
            MODE_HSTRIPE: bg = vpos[PIX_W-1:0];
            default: begin
                for (int c = 0; c < 3; c++) begin
                    if (mode_w == MODE_SCROLL_XP || mode_w == MODE_SCROLL_XN)
                        msb = mx[5+c];
                    else
                        msb = my[5+c];
                    if (mode_w <= MODE_SCROLL_YN)
                        lsb = vpos[2];
                    else
                        lsb = mx[2];
                    for (int b = 0; b < COLOR_BITS; b++)
                        bg[(2-c)*COLOR_BITS+b] = (b == COLOR_BITS-1) ? msb : lsb;
                end
            end
        endcase
    end

`ifdef PATTERN_ENGINE_SPRITE_KEY_EN
    assign opaque = |sprite_rgb;
`else
    assign opaque = 1'b1;
`endif

    assign in_win = win_en && (hpos >= X0) && (hpos <= X1);

    always_comb begin
        pix_d = '0;
        if (visible)
            pix_d = (in_win && opaque) ? sprite_rgb : bg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rgb_q <= '0;
        else
            rgb_q <= pix_d;
    end

    assign rgb  = rgb_q;
    assign mode = mode_w;

endmodule

// File: tb/tb_pattern_engine.sv
// Directed self-checking bench for pattern_engine (FRAMES_PER_MODE=4).
module tb_pattern_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos, vpos;
    logic       visible, vsync, auto_en, win_en;
    logic [3:0] mode_sel;
    logic [5:0] sprite_rgb;
    logic [5:0] rgb;
    logic [3:0] mode;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;
    int cur_mode;

    typedef struct {
        int         md;
        logic [9:0] h;
        logic [9:0] v;
        logic       vis;
        logic       we;
        logic [5:0] spr;
        logic [5:0] exp;
    } vec_t;

    vec_t vt[12];

    always #5 clk = ~clk;

    pattern_engine #(
        .COLOR_BITS     (2),
        .POS_BITS       (10),
        .FRAMES_PER_MODE(4),
        .SCROLL_STEP    (1),
        .WIN_X0         (100),
        .WIN_X1         (500),
        .SOLID_RGB      (6'b110000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hpos      (hpos),
        .vpos      (vpos),
        .visible   (visible),
        .vsync     (vsync),
        .auto_en   (auto_en),
        .mode_sel  (mode_sel),
        .win_en    (win_en),
        .sprite_rgb(sprite_rgb),
        .rgb       (rgb),
        .mode      (mode),
        .frame_tick(frame_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic frame();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++)
            frame();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v,
                       input string name, input logic [5:0] exp);
        hpos = h;
        vpos = v;
        visible = 1'b1;
        win_en = 1'b0;
        step();
        check(name, rgb, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        hpos = '0;
        vpos = '0;
        visible = 1'b0;
        vsync = 1'b0;
        auto_en = 1'b0;
        mode_sel = '0;
        win_en = 1'b0;
        sprite_rgb = '0;

        vt[0]  = '{0, 10'd50,  10'd0,    1'b0, 1'b0, 6'o00, 6'b000000};
        vt[1]  = '{0, 10'd50,  10'd0,    1'b1, 1'b0, 6'o00, 6'b110000};
        vt[2]  = '{0, 10'd100, 10'd0,    1'b1, 1'b1, 6'o14, 6'b001100};
        vt[3]  = '{0, 10'd500, 10'd0,    1'b1, 1'b1, 6'o14, 6'b001100};
        vt[4]  = '{0, 10'd501, 10'd0,    1'b1, 1'b1, 6'o14, 6'b110000};
        vt[5]  = '{0, 10'd99,  10'd0,    1'b1, 1'b1, 6'o14, 6'b110000};
        vt[6]  = '{0, 10'd200, 10'd0,    1'b1, 1'b0, 6'o14, 6'b110000};
        vt[7]  = '{1, 10'h2AB, 10'd0,    1'b1, 1'b0, 6'o00, 6'b101011};
        vt[8]  = '{1, 10'd37,  10'd0,    1'b1, 1'b0, 6'o00, 6'b100101};
        vt[9]  = '{2, 10'd0,   10'h03C,  1'b1, 1'b0, 6'o00, 6'b111100};
        vt[10] = '{2, 10'd0,   10'h03C,  1'b0, 1'b0, 6'o00, 6'b000000};
`ifdef PATTERN_ENGINE_SPRITE_KEY_EN
        vt[11] = '{0, 10'd300, 10'd0,    1'b1, 1'b1, 6'o00, 6'b110000};
`else
        vt[11] = '{0, 10'd300, 10'd0,    1'b1, 1'b1, 6'o00, 6'b000000};
`endif

        do_reset();
        check("reset_rgb", rgb, 0);
        check("reset_mode", mode, 0);
        check("reset_tick", frame_tick, 0);
        hpos = 10'd777;
        step();
        check("invisible_rgb", rgb, 0);

        // first frame: tick pulse is exactly one cycle; scroll becomes 1
        mode_sel = 4'd3;
        vsync = 1'b1;
        step();
        check("tick_high", frame_tick, 1);
        step();
        check("tick_one_cycle", frame_tick, 0);
        check("mode_after_tick", mode, 3);
        vsync = 1'b0;
        step();
        pix(10'd31, 10'd4, "scroll_is_1", 6'b110101);

        // manual select changes only at the frame boundary
        mode_sel = 4'd5;
        step();
        step();
        check("mode_held_midframe", mode, 3);
        frame();
        check("mode_sel_5", mode, 5);
        mode_sel = 4'd12;
        frame();
        check("mode_sel_12", mode, 0);

        // table vectors on scroll-independent modes
        cur_mode = 0;
        for (int i = 0; i < 12; i++) begin
            if (vt[i].md != cur_mode) begin
                mode_sel = 4'(vt[i].md);
                frame();
                cur_mode = vt[i].md;
            end
            hpos = vt[i].h;
            vpos = vt[i].v;
            visible = vt[i].vis;
            win_en = vt[i].we;
            sprite_rgb = vt[i].spr;
            step();
            check($sformatf("vec%0d", i), rgb, vt[i].exp);
        end
        win_en = 1'b0;

        // auto cycling, 4 frames per mode, wrap from 10 back to 0
        do_reset();
        auto_en = 1'b1;
        frames(3);
        check("auto_3_frames", mode, 0);
        frame();
        check("auto_4_frames", mode, 1);
        frames(4);
        check("auto_8_frames", mode, 2);
        frames(36);
        check("auto_44_frames", mode, 0);

        // mid-frame reset clears mode
        frames(4);
        rst_n = 1'b0;
        step();
        check("midframe_reset_mode", mode, 0);
        rst_n = 1'b1;
        auto_en = 1'b0;
        step();

        // scroll wrap 1023 -> 0 in mode 3
        mode_sel = 4'd3;
        frames(1023);
        check("mode3_loaded", mode, 3);
        pix(10'd64, 10'd4, "scroll_1023", 6'b110101);
        frame();
        pix(10'd32, 10'd4, "scroll_wrap_0", 6'b110101);
        pix(10'd64, 10'd4, "scroll_0_h64", 6'b011101);

        mode_sel = 4'd4;
        frame();
        pix(10'd33, 10'd0, "mode4_minus_x", 6'b100000);
        mode_sel = 4'd7;
        frame();
        pix(10'd2, 10'd30, "mode7_pp", 6'b110101);
        mode_sel = 4'd10;
        frame();
        pix(10'd7, 10'd131, "mode10_nn", 6'b010111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
